// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into an indexed word store.
// Latency: start at edge 0 -> done in the cycle after edge 1+G (41/47/53 edges); rk_out is one cycle after rk_idx.
// No backpressure: start is honoured only in IDLE/READY, ignored while busy, rejected with an err pulse if illegal.
module aes_key_expander_seq #(
  parameter int KEY_MAX = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         key_len,
  input  logic [0:KEY_MAX-1] key_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic [3:0]         rk_idx,
  output logic [127:0]       rk_out,
  output logic               rk_valid
);

  localparam int NW    = 4 * (KEY_MAX / 32 + 7);
  localparam int NKMAX = KEY_MAX / 32;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY} state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (b^254, which also maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 7; k++) r = gmul(gmul(r, r), b);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    len_q, len_d;
  logic [5:0]    i_q, i_d;
  logic [2:0]    sub_q, sub_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rk_valid_q, rk_valid_d;
  logic [127:0]  rk_out_q, rk_out_d;

  logic [31:0]   w_q [0:NW-1];

  logic          start_ok, len_legal, accept, reject;
  logic [3:0]    nk_cur, nr_cur, nk_key;
  logic [5:0]    last_idx, rd_base;
  logic [31:0]   prev_w, back_w, rot_w, t_w, exp_word;
  logic          exp_we, rd_ok;

  assign nk_key    = nk_of(key_len);
  assign nk_cur    = nk_of(len_q);
  assign nr_cur    = nk_cur + 4'd6;
  assign last_idx  = {nk_cur, 2'b00} + 6'd27;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_READY);
  assign len_legal = (key_len != 2'd3) && ((32 * int'(nk_key)) <= KEY_MAX);
  assign accept    = start_ok && len_legal;
  assign reject    = start_ok && !len_legal;

  // Next schedule word from w[i-1] and w[i-Nk]; sub_q tracks i mod Nk.
  always_comb begin
    prev_w = w_q[i_q - 6'd1];
    back_w = w_q[i_q - {2'b00, nk_cur}];
    rot_w  = {prev_w[23:0], prev_w[31:24]};
    if (sub_q == 3'd0) begin
      t_w = sub_word(rot_w) ^ {rcon_q, 24'h000000};
    end else if (nk_cur == 4'd8 && sub_q == 3'd4) begin
      t_w = sub_word(prev_w);
    end else begin
      t_w = prev_w;
    end
    exp_word = back_w ^ t_w;
  end

  // Control FSM next-state, counters and status pulses.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    i_d     = i_q;
    sub_d   = sub_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = reject;
    exp_we  = 1'b0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (accept) begin
          len_d   = key_len;
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        i_d     = {2'b00, nk_cur};
        sub_d   = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        exp_we = 1'b1;
        i_d    = i_q + 6'd1;
        sub_d  = (sub_q == 3'(nk_cur - 4'd1)) ? 3'd0 : sub_q + 3'd1;
        if (sub_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_idx) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read port: a restart accepted this cycle invalidates the old schedule immediately.
  always_comb begin
    rd_base    = {rk_idx, 2'b00};
    rd_ok      = (state_q == S_READY) && !accept && (rk_idx <= nr_cur);
    rk_valid_d = rd_ok;
    rk_out_d   = 128'h0;
    if (rd_ok) begin
      rk_out_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

  // Word store: key words are captured at the accept edge so key_in only has to be valid with start.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int j = 0; j < NKMAX; j++) begin
        if (j < int'(nk_key)) w_q[j] <= key_in[32*j +: 32];
      end
    end
    if (!rst && exp_we) w_q[i_q] <= exp_word;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 2'd0;
      i_q        <= 6'd0;
      sub_q      <= 3'd0;
      rcon_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= 128'h0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      i_q        <= i_d;
      sub_q      <= sub_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;

endmodule
